// File: rtl/cpu_program_loader.sv
`default_nettype none
// ============================================================================
// Module  : cpu_program_loader
// Brief   : Holds Pipe_CPU_1 in reset, clears IM/DM, loads a big-endian byte
//           stream into IM, then releases the CPU.
// Revision: 1.0 - initial release
// ============================================================================
module cpu_program_loader #(
    parameter int IM_WORDS = 32,
    parameter int DM_BYTES = 128,
    parameter int IAW      = $clog2(IM_WORDS),
    parameter int DAW      = $clog2(DM_BYTES)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [IAW:0]   len_i,
    input  logic           byte_valid_i,
    input  logic [7:0]     byte_i,
    output logic           byte_ready_o,
    output logic           im_we_o,
    output logic [IAW-1:0] im_addr_o,
    output logic [31:0]    im_wdata_o,
    output logic           dm_we_o,
    output logic [DAW-1:0] dm_addr_o,
    output logic [7:0]     dm_wdata_o,
    output logic           cpu_rst_n_o,
    output logic           busy_o,
    output logic           done_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR_IM = 3'd1,
        S_CLR_DM = 3'd2,
        S_LOAD   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [IAW:0]   IM_DEPTH = (IAW+1)'(IM_WORDS);
    localparam logic [IAW-1:0] IM_LAST  = IAW'(IM_WORDS - 1);
    localparam logic [DAW-1:0] DM_LAST  = DAW'(DM_BYTES - 1);

    state_t         state;
    state_t         state_nxt;
    logic [IAW-1:0] im_cnt;
    logic [DAW-1:0] dm_cnt;
    logic [IAW:0]   n_words;
    logic [IAW:0]   word_idx;
    logic [1:0]     byte_cnt;
    logic [31:0]    assembler;
    logic           wr_pending;
    logic           cpu_run;
    logic [IAW:0]   len_clamped;

    assign len_clamped = (len_i > IM_DEPTH) ? IM_DEPTH : len_i;
    assign dm_wdata_o  = 8'h00;
    assign cpu_rst_n_o = cpu_run;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        byte_ready_o = 1'b0;
        im_we_o      = 1'b0;
        im_addr_o    = '0;
        im_wdata_o   = '0;
        dm_we_o      = 1'b0;
        dm_addr_o    = '0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_nxt = S_CLR_IM;
                end
            end
            S_CLR_IM: begin
                busy_o    = 1'b1;
                im_we_o   = 1'b1;
                im_addr_o = im_cnt;
                if (im_cnt == IM_LAST) begin
                    state_nxt = S_CLR_DM;
                end
            end
            S_CLR_DM: begin
                busy_o    = 1'b1;
                dm_we_o   = 1'b1;
                dm_addr_o = dm_cnt;
                if (dm_cnt == DM_LAST) begin
                    state_nxt = (n_words == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                busy_o = 1'b1;
                // The word-write cycle blocks the byte port so the assembler is stable
                if (wr_pending) begin
                    im_we_o    = 1'b1;
                    im_addr_o  = word_idx[IAW-1:0];
                    im_wdata_o = assembler;
                    if (word_idx == n_words - 1'b1) begin
                        state_nxt = S_DONE;
                    end
                end else begin
                    byte_ready_o = 1'b1;
                end
            end
            S_DONE: begin
                done_o    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            im_cnt     <= '0;
            dm_cnt     <= '0;
            n_words    <= '0;
            word_idx   <= '0;
            byte_cnt   <= '0;
            assembler  <= '0;
            wr_pending <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        n_words    <= len_clamped;
                        im_cnt     <= '0;
                        dm_cnt     <= '0;
                        word_idx   <= '0;
                        byte_cnt   <= '0;
                        assembler  <= '0;
                        wr_pending <= 1'b0;
                    end
                end
                S_CLR_IM: im_cnt <= im_cnt + 1'b1;
                S_CLR_DM: dm_cnt <= dm_cnt + 1'b1;
                S_LOAD: begin
                    if (wr_pending) begin
                        wr_pending <= 1'b0;
                        word_idx   <= word_idx + 1'b1;
                    end else if (byte_valid_i) begin
                        // First byte of a word ends up in bits [31:24]
                        assembler <= {assembler[23:0], byte_i};
                        byte_cnt  <= byte_cnt + 1'b1;
                        if (byte_cnt == 2'd3) begin
                            wr_pending <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // CPU reset is asserted from the cycle after start and released in DONE
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cpu_run <= 1'b0;
        end else if (state == S_IDLE && start_i) begin
            cpu_run <= 1'b0;
        end else if (state_nxt == S_DONE) begin
            cpu_run <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_program_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu_program_loader
// Brief   : Self-checking bench for cpu_program_loader (cycle model + literals).
// Revision: 1.0 - initial release
// ============================================================================
module tb_cpu_program_loader;
    localparam int IMW = 32;
    localparam int DMB = 128;
    localparam int IAW = 5;
    localparam int DAW = 7;
    localparam int CLR_END = IMW + DMB;

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b1;
    logic           start_i = 1'b0;
    logic [IAW:0]   len_i = '0;
    logic           byte_valid_i = 1'b0;
    logic [7:0]     byte_i = 8'h00;
    logic           byte_ready_o;
    logic           im_we_o;
    logic [IAW-1:0] im_addr_o;
    logic [31:0]    im_wdata_o;
    logic           dm_we_o;
    logic [DAW-1:0] dm_addr_o;
    logic [7:0]     dm_wdata_o;
    logic           cpu_rst_n_o;
    logic           busy_o;
    logic           done_o;

    cpu_program_loader #(.IM_WORDS(IMW), .DM_BYTES(DMB)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
        .byte_valid_i(byte_valid_i), .byte_i(byte_i), .byte_ready_o(byte_ready_o),
        .im_we_o(im_we_o), .im_addr_o(im_addr_o), .im_wdata_o(im_wdata_o),
        .dm_we_o(dm_we_o), .dm_addr_o(dm_addr_o), .dm_wdata_o(dm_wdata_o),
        .cpu_rst_n_o(cpu_rst_n_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // Model: m_k counts cycles since start; 1..IMW clear IM, IMW+1..CLR_END clear DM
    int          m_k = 0;
    int          m_n = 0;
    int          m_words = 0;
    int          m_bytes = 0;
    bit          m_active = 0;
    bit          m_done = 0;
    bit          m_write = 0;
    bit          m_rel = 0;
    logic [31:0] m_word = '0;

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m_k <= 0; m_n <= 0; m_words <= 0; m_bytes <= 0;
            m_active <= 0; m_done <= 0; m_write <= 0; m_rel <= 0; m_word <= '0;
        end else if (m_done) begin
            m_done <= 0;
        end else if (!m_active) begin
            if (start_i) begin
                m_active <= 1; m_k <= 1; m_words <= 0; m_bytes <= 0;
                m_write <= 0; m_rel <= 0;
                m_n <= (int'(len_i) > IMW) ? IMW : int'(len_i);
            end
        end else if (m_k < CLR_END) begin
            m_k <= m_k + 1;
        end else if (m_k == CLR_END) begin
            if (m_n == 0) begin
                m_active <= 0; m_done <= 1; m_rel <= 1;
            end else begin
                m_k <= CLR_END + 1;
            end
        end else if (m_write) begin
            m_write <= 0;
            m_words <= m_words + 1;
            if (m_words + 1 == m_n) begin
                m_active <= 0; m_done <= 1; m_rel <= 1;
            end
        end else if (byte_valid_i) begin
            m_word <= {m_word[23:0], byte_i};
            if (m_bytes == 3) begin
                m_bytes <= 0; m_write <= 1;
            end else begin
                m_bytes <= m_bytes + 1;
            end
        end
    end

    logic [57:0] got_vec;
    logic [57:0] exp_vec;
    assign got_vec = {byte_ready_o, im_we_o, im_addr_o, im_wdata_o, dm_we_o, dm_addr_o,
                      dm_wdata_o, cpu_rst_n_o, busy_o, done_o};

    always_comb begin
        logic           e_rdy, e_imwe, e_dmwe;
        logic [IAW-1:0] e_ima;
        logic [31:0]    e_imd;
        logic [DAW-1:0] e_dma;
        e_rdy = 0; e_imwe = 0; e_dmwe = 0; e_ima = '0; e_imd = '0; e_dma = '0;
        if (m_active) begin
            if (m_k >= 1 && m_k <= IMW) begin
                e_imwe = 1; e_ima = IAW'(m_k - 1);
            end else if (m_k > IMW && m_k <= CLR_END) begin
                e_dmwe = 1; e_dma = DAW'(m_k - IMW - 1);
            end else if (m_k > CLR_END) begin
                if (m_write) begin
                    e_imwe = 1; e_ima = IAW'(m_words); e_imd = m_word;
                end else begin
                    e_rdy = 1;
                end
            end
        end
        exp_vec = {e_rdy, e_imwe, e_ima, e_imd, e_dmwe, e_dma, 8'h00, m_rel, m_active, m_done};
    end

    logic [31:0] shadow_im [IMW];
    int          im_wr_cnt = 0;
    int          dm_wr_cnt = 0;

    initial begin
        for (int i = 0; i < IMW; i++) shadow_im[i] = 32'hFFFF_FFFF;
    end

    always @(negedge clk_i) begin
        chk("cycle_outputs", 64'(got_vec), 64'(exp_vec));
        if (rst_i && im_we_o) begin
            shadow_im[im_addr_o] <= im_wdata_o;
            im_wr_cnt <= im_wr_cnt + 1;
        end
        if (rst_i && dm_we_o) dm_wr_cnt <= dm_wr_cnt + 1;
    end

    logic [7:0] prog [0:131];

    // Runs one sequence; entered and left at #1 after a rising edge
    task automatic run_seq(input int len, input int nb, input bit toggle, input bit busy_start,
                           input int abort_at, output int lat, output int stalls,
                           output int rdy_seen);
        int idx;
        bit hs;
        idx = 0; lat = 0; stalls = 0; rdy_seen = 0;
        im_wr_cnt = 0; dm_wr_cnt = 0;
        start_i = 1'b1;
        len_i = (IAW+1)'(len);
        while (lat < 2000) begin
            byte_valid_i = (idx < nb) && (!toggle || (lat % 2 == 0));
            byte_i = (idx < nb) ? prog[idx] : 8'h00;
            if (busy_start && lat == 60) start_i = 1'b1;
            hs = byte_valid_i && byte_ready_o;
            if (byte_ready_o) rdy_seen++;
            if (byte_ready_o && !byte_valid_i) stalls++;
            @(posedge clk_i);
            #1;
            lat++;
            start_i = 1'b0;
            if (hs) idx++;
            if (abort_at >= 0 && idx == abort_at) begin
                rst_i = 1'b0;
                byte_valid_i = 1'b0;
                return;
            end
            if (done_o) break;
        end
        if (!done_o) chk("done_timeout", 64'(lat), 64'd0);
        byte_valid_i = 1'b0;
    endtask

    int lat, stalls, rdy;

    initial begin
        #2 rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("in_reset_outputs", 64'(got_vec), 64'd0);
        rst_i = 1'b1;
        repeat (10) @(posedge clk_i);
        #1;
        chk("idle_after_reset", 64'(got_vec), 64'd0);

        // Two-word program, bytes every cycle
        prog[0] = 8'h8C; prog[1] = 8'h01; prog[2] = 8'h00; prog[3] = 8'h00;
        prog[4] = 8'h20; prog[5] = 8'h02; prog[6] = 8'h00; prog[7] = 8'h05;
        run_seq(2, 8, 0, 0, -1, lat, stalls, rdy);
        chk("len2_latency", 64'(lat), 64'd171);
        chk("len2_cpu_released", 64'(cpu_rst_n_o), 64'd1);
        #5;
        chk("len2_im_writes", 64'(im_wr_cnt), 64'd34);
        chk("len2_dm_writes", 64'(dm_wr_cnt), 64'd128);
        chk("len2_im0", 64'(shadow_im[0]), 64'h8C01_0000);
        chk("len2_im1", 64'(shadow_im[1]), 64'h2002_0005);
        chk("len2_im2_cleared", 64'(shadow_im[2]), 64'd0);
        @(posedge clk_i); #1;

        // Same program with byte_valid toggling and a start while busy
        run_seq(2, 8, 1, 1, -1, lat, stalls, rdy);
        chk("toggle_latency", 64'(lat), 64'(171 + stalls));
        chk("toggle_has_stalls", 64'(stalls > 0), 64'd1);
        #5;
        chk("toggle_im_writes", 64'(im_wr_cnt), 64'd34);
        chk("toggle_im0", 64'(shadow_im[0]), 64'h8C01_0000);
        chk("toggle_im1", 64'(shadow_im[1]), 64'h2002_0005);
        @(posedge clk_i); #1;

        // Clear-only
        run_seq(0, 8, 0, 0, -1, lat, stalls, rdy);
        chk("len0_latency", 64'(lat), 64'd161);
        chk("len0_no_ready", 64'(rdy), 64'd0);
        #5;
        chk("len0_im0_cleared", 64'(shadow_im[0]), 64'd0);
        @(posedge clk_i); #1;

        // Clamp: 40 requested, 33 words of bytes offered
        for (int i = 0; i < 132; i++) prog[i] = 8'(i + 1);
        run_seq(40, 132, 0, 0, -1, lat, stalls, rdy);
        chk("len40_latency", 64'(lat), 64'd321);
        #5;
        chk("len40_im_writes", 64'(im_wr_cnt), 64'd64);
        chk("len40_im0", 64'(shadow_im[0]), 64'h0102_0304);
        chk("len40_im31", 64'(shadow_im[31]), 64'h7D7E_7F80);
        @(posedge clk_i); #1;
        for (int i = 0; i < 3; i++) begin
            byte_valid_i = 1'b1; byte_i = 8'h81;
            chk("len40_no_ready_after_done", 64'(byte_ready_o), 64'd0);
            @(posedge clk_i); #1;
        end
        byte_valid_i = 1'b0;

        // Abort after two bytes of word 1, then reload one word
        prog[0] = 8'h8C; prog[1] = 8'h01; prog[2] = 8'h00; prog[3] = 8'h00;
        prog[4] = 8'h20; prog[5] = 8'h02; prog[6] = 8'h00; prog[7] = 8'h05;
        run_seq(2, 8, 0, 0, 6, lat, stalls, rdy);
        #4;
        chk("abort_cpu_in_reset", 64'(cpu_rst_n_o), 64'd0);
        chk("abort_im_writes", 64'(im_wr_cnt), 64'd33);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        prog[0] = 8'hDE; prog[1] = 8'hAD; prog[2] = 8'hBE; prog[3] = 8'hEF;
        run_seq(1, 4, 0, 0, -1, lat, stalls, rdy);
        chk("restart_latency", 64'(lat), 64'd166);
        chk("restart_cpu_released", 64'(cpu_rst_n_o), 64'd1);
        #5;
        chk("restart_im0", 64'(shadow_im[0]), 64'hDEAD_BEEF);
        chk("restart_im1_cleared", 64'(shadow_im[1]), 64'd0);
        repeat (4) @(posedge clk_i);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cpu_program_loader.md
Name: cpu_program_loader

Overview:
- Hardware counterpart to bench-side memory preloading for Pipe_CPU_1.
- Holds the CPU in reset, clears the instruction and data memories, and writes a program into instruction memory from a byte stream.
- Releases CPU reset when loading completes.
- Sits between a host byte source (UART/JTAG bridge) and the CPU's IM/DM write ports.

Parameters:
IM_WORDS, 32, instruction memory depth in 32-bit words
DM_BYTES, 128, data memory depth in bytes
IAW, $clog2(IM_WORDS), instruction word address width
DAW, $clog2(DM_BYTES), data byte address width

Ports:
clk_i  in  1  system clock; all logic on rising edge
rst_i  in  1  asynchronous active-low reset
start_i  in  1  begin a load sequence; sampled in IDLE only
len_i  in  IAW+1  number of words to load; sampled with start_i
byte_valid_i  in  1  host byte valid
byte_i  in  8  host byte
byte_ready_o  out  1  loader accepts byte this cycle
im_we_o  out  1  instruction memory write enable
im_addr_o  out  IAW  instruction word index
im_wdata_o  out  32  instruction word
dm_we_o  out  1  data memory write enable
dm_addr_o  out  DAW  data byte address
dm_wdata_o  out  8  data byte (always 0)
cpu_rst_n_o  out  1  active-low reset to Pipe_CPU_1 rst_i
busy_o  out  1  sequence in progress
done_o  out  1  one-cycle pulse at completion

Behaviour:
- Reset (rst_i=0, asynchronous): state IDLE.
  - All outputs 0, including cpu_rst_n_o=0 (CPU held in reset).
  - Byte assembler and counters cleared.
- States: IDLE -> CLR_IM -> CLR_DM -> LOAD -> DONE -> IDLE.
- IDLE:
  - byte_ready_o=0. cpu_rst_n_o holds its last value (0 after reset, 1 after a completed load).
  - start_i=1: latch n = min(len_i, IM_WORDS), drive cpu_rst_n_o=0 and busy_o=1 from the next cycle, go to CLR_IM.
- CLR_IM:
  - One write per cycle: im_we_o=1, im_wdata_o=0, im_addr_o=0..IM_WORDS-1.
  - Exactly IM_WORDS cycles, then CLR_DM.
- CLR_DM:
  - One write per cycle: dm_we_o=1, dm_wdata_o=0, dm_addr_o=0..DM_BYTES-1.
  - Exactly DM_BYTES cycles.
  - Next state is LOAD if n>0, else DONE.
- LOAD:
  - byte_ready_o=1 except in the single cycle in which a completed word is written.
  - Each handshake (byte_valid_i & byte_ready_o) shifts byte_i into a 32-bit assembler, first byte to bits[31:24] (big-endian, matching program text order).
  - On the 4th accepted byte, the next cycle drives im_we_o=1, im_addr_o=word index, im_wdata_o=assembled word. byte_ready_o=0 in that cycle.
  - Word index starts at 0 and increments after each write. After write n-1, go to DONE.
  - byte_valid_i low stalls indefinitely; no timeout.
- DONE: lasts one cycle.
  - done_o=1, busy_o=0 in this cycle.
  - cpu_rst_n_o rises to 1 in this cycle and stays 1 until the next start or reset.
  - Return to IDLE.
- Write enables are 0 in every state except as stated above. im_we_o and dm_we_o are never both 1.
- Minimum sequence latency, start to done_o: 1 + IM_WORDS + DM_BYTES + 5n cycles (4 byte cycles + 1 write cycle per word).
- Boundary conditions:
  - start_i while busy_o=1: ignored.
  - len_i > IM_WORDS: clamped to IM_WORDS.
  - len_i = 0: clear-only sequence, then CPU released.
  - byte_valid_i outside LOAD: no effect; bytes are not buffered.
  - Reset mid-sequence: immediate abort. Partial word is discarded, memories are left partially written, cpu_rst_n_o=0.
  - Restart after DONE: CPU is re-reset and memories are re-cleared before the new load.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0, cpu_rst_n_o=0, byte_ready_o=0.
- start_i with len_i=2, bytes 8C,01,00,00,20,02,00,05 presented every cycle -> 32 IM clears, 128 DM clears, IM[0]=0x8C010000, IM[1]=0x20020005; done_o pulses exactly 1+32+128+10=171 cycles after start; cpu_rst_n_o=1 from that cycle.
- Same load with byte_valid_i toggling every other cycle -> identical memory contents; no byte lost or duplicated; done_o delayed by the stall count.
- len_i=0 -> clears only; done_o at cycle 161; byte_ready_o never asserted.
- len_i=40 -> exactly 32 words written to addresses 0..31; 33rd word's bytes not accepted (byte_ready_o=0 after DONE).
- Reset asserted after 2 bytes of word 1, then restart with len_i=1 -> no IM write at index 1 from the aborted run; CPU stays in reset until the new done_o; IM[0] holds the new word.
